pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Parametrised stall/flush controller for the in-order RV32I pipeline. It generalises the hazard unit to N stages and adds three behaviours:
- a multi-cycle load-use bubble counter;
- x0-aware dependency checking;
- a redirect-pending FSM that squashes a wrong-path fetch still in flight when a misprediction resolves.

It drives PC enable and every pipeline-register enable/flush.

Parameters:
NUM_STAGES, 5, pipeline stages (min 4); stage 0 = IF, 1 = ID, 2 = EX, NUM_STAGES-2 = MEM.
LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (1..4).
REG_ADDR_W, 5, register-index width.
CNT_W, 32, perf-counter width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
imem_resp  in  1  I-mem fetch complete this cycle
dmem_req  in  1  MEM-stage read or write outstanding
dmem_resp  in  1  D-mem response this cycle
ex_busy  in  1  multi-cycle EX unit (MDU) not done
rs1_id  in  REG_ADDR_W  ID-stage source 1
rs2_id  in  REG_ADDR_W  ID-stage source 2
ex_is_load  in  1  EX-stage instruction is a load
rd_ex  in  REG_ADDR_W  EX-stage destination
redirect  in  1  EX-stage misprediction (level, held while resolving instr in EX)
stage_en  out  NUM_STAGES  bit0 = pc_en; bit i = enable of register feeding stage i
stage_flush  out  NUM_STAGES  bit i = load bubble into register i (bit0 unused, 0)
tgt_capture  out  1  datapath registers redirect target this cycle
tgt_held_sel  out  1  PC mux selects held target
predict_en  out  1  branch predictor update enable
stall_cnt  out  CNT_W  stall-cycle counter (feature)
flush_cnt  out  CNT_W  flush-event counter (feature)

Behaviour:
- Reset (async): state = IDLE, lu_cnt = 0, counters = 0. While rst is high, all outputs are 0.
- back_ok = (~dmem_req | dmem_resp) & ~ex_busy. front_ok = imem_resp.
- lu_hit = ex_is_load & (rd_ex != 0) & (rd_ex == rs1_id | rd_ex == rs2_id).
- Default stage-enable rules (all combinational from state and inputs):
  - ~back_ok: all enables 0, all flushes 0.
  - back_ok & front_ok: all enables 1.
  - back_ok & ~front_ok: enables 1..N-1 = 1, flush[1] = 1, pc_en = 0.
- Priority: redirect > load-use > default.
- Redirect, when back_ok & redirect:
  - Always: en/flush[1] = 1, en/flush[2] = 1. lu_cnt cleared, load-use suppressed.
  - If front_ok: pc_en = 1 (target from EX), stay/return IDLE.
  - Else: pc_en = 0, tgt_capture = 1 for one cycle, next state REDIR_WAIT.
- REDIR_WAIT:
  - tgt_held_sel = 1. flush[1] = 1 whenever en[1] = 1.
  - On imem_resp (wrong-path fetch retires): pc_en = 1 only if back_ok, loading the held target; then IDLE. If imem_resp arrives without back_ok, hold the state.
  - A new redirect in REDIR_WAIT re-captures the target and stays in REDIR_WAIT.
- Load-use, when back_ok & lu_hit in IDLE:
  - pc_en = 0, en[1] = 0, en[2] = 1, flush[2] = 1.
  - If LOAD_USE_STALLS > 1: lu_cnt = LOAD_USE_STALLS-1, next state LU_STALL.
- LU_STALL:
  - Each back_ok cycle: same hold/bubble pattern as the load-use case, lu_cnt--.
  - When the pattern is applied with lu_cnt == 1, next state IDLE.
  - ~back_ok: freeze.
- predict_en = en[1] | en[2].
- An illegal state decodes as IDLE.
- Reset asserted mid-REDIR_WAIT or mid-LU_STALL aborts to IDLE immediately.

Optional Feature:
HAZARD_PERF_EN:
- Defined: stall_cnt increments every cycle pc_en = 0 outside reset. flush_cnt increments on each cycle any flush bit is 1. Both saturate at all-ones.
- Undefined: both outputs tied to 0, no counter flops.

Test Plan:
- imem_resp = 1, dmem_req = 0, ex_busy = 0, no hazards -> stage_en = 5'b11111, stage_flush = 0 every cycle.
- ex_is_load = 1, rd_ex = 5, rs1_id = 5, LOAD_USE_STALLS = 2 -> two back_ok cycles with pc_en = 0, en[1] = 0, flush[2] = 1, then normal advance. Repeat with rd_ex = 0 -> no stall.
- redirect = 1 with imem_resp = 1 -> pc_en = 1, flush[1] = flush[2] = 1 in the same cycle, state stays IDLE.
- redirect = 1 with imem_resp = 0, then imem_resp after 3 cycles -> tgt_capture pulse in cycle 0, tgt_held_sel = 1 for 4 cycles, the returning fetch is flushed, pc_en = 1 on the response cycle.
- dmem_req = 1, dmem_resp = 0 for 4 cycles while lu_hit -> all enables 0 and lu_cnt frozen. On dmem_resp, the stall sequence resumes.
- rst pulsed during REDIR_WAIT -> all outputs 0 immediately; after release, state IDLE and tgt_held_sel = 0. With HAZARD_PERF_EN defined, counters read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs and stall/flush outputs of the hazard controller
interface pipeline_hazard_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  imem_resp;
  logic                  dmem_req;
  logic                  dmem_resp;
  logic                  ex_busy;
  logic [REG_ADDR_W-1:0] rs1_id;
  logic [REG_ADDR_W-1:0] rs2_id;
  logic                  ex_is_load;
  logic [REG_ADDR_W-1:0] rd_ex;
  logic                  redirect;
  logic [NUM_STAGES-1:0] stage_en;
  logic [NUM_STAGES-1:0] stage_flush;
  logic                  tgt_capture;
  logic                  tgt_held_sel;
  logic                  predict_en;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;
  modport master (
    output imem_resp, dmem_req, dmem_resp, ex_busy, rs1_id, rs2_id, ex_is_load, rd_ex, redirect,
    input  stage_en, stage_flush, tgt_capture, tgt_held_sel, predict_en, stall_cnt, flush_cnt
  );
  modport slave (
    input  imem_resp, dmem_req, dmem_resp, ex_busy, rs1_id, rs2_id, ex_is_load, rd_ex, redirect,
    output stage_en, stage_flush, tgt_capture, tgt_held_sel, predict_en, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: N-stage stall/flush controller; HAZARD_PERF_EN adds stall/flush perf counters
module pipeline_hazard_ctrl #(
  parameter int NUM_STAGES      = 5,
  parameter int LOAD_USE_STALLS = 1,
  parameter int REG_ADDR_W      = 5,
  parameter int CNT_W           = 32
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {IDLE, REDIR_WAIT, LU_STALL} state_t;
  localparam logic [NUM_STAGES-1:0] ALL = {NUM_STAGES{1'b1}};
  localparam logic [REG_ADDR_W-1:0] X0 = '0;
  state_t state_q, state_d, st;
  logic [1:0] lu_q, lu_d;
  logic [NUM_STAGES-1:0] en, fl;
  logic cap, back_ok, front_ok, lu_hit;
  assign back_ok  = (~hz.dmem_req | hz.dmem_resp) & ~hz.ex_busy;
  assign front_ok = hz.imem_resp;
  assign lu_hit   = hz.ex_is_load & (hz.rd_ex != X0) & (hz.rd_ex == hz.rs1_id | hz.rd_ex == hz.rs2_id);
  assign st       = (state_q inside {REDIR_WAIT, LU_STALL}) ? state_q : IDLE;
  // state and remaining load-use bubble count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lu_q    <= '0;
    end else begin
      state_q <= state_d;
      lu_q    <= lu_d;
    end
  end
  // enables/flushes by priority: backend stall, redirect, pending redirect, load-use, default
  always_comb begin
    en      = '0;
    fl      = '0;
    cap     = 1'b0;
    state_d = st;
    lu_d    = lu_q;
    if (back_ok) begin
      if (hz.redirect) begin
        en      = ALL;
        fl[2:1] = 2'b11;
        lu_d    = '0;
        if (front_ok && st != REDIR_WAIT) begin
          state_d = IDLE;
        end else begin
          en[0]   = 1'b0;
          cap     = 1'b1;
          state_d = REDIR_WAIT;
        end
      end else if (st == REDIR_WAIT) begin
        en      = ALL;
        en[0]   = front_ok;
        fl[1]   = 1'b1;
        state_d = front_ok ? IDLE : REDIR_WAIT;
      end else if (st == LU_STALL || lu_hit) begin
        en      = ALL;
        en[1:0] = 2'b00;
        fl[2]   = 1'b1;
        if (st == LU_STALL) begin
          lu_d    = lu_q - 2'd1;
          state_d = (lu_q == 2'd1) ? IDLE : LU_STALL;
        end else if (LOAD_USE_STALLS > 1) begin
          lu_d    = 2'(LOAD_USE_STALLS - 1);
          state_d = LU_STALL;
        end
      end else begin
        en    = ALL;
        en[0] = front_ok;
        fl[1] = ~front_ok;
      end
    end
  end
  assign hz.stage_en     = rst ? '0 : en;
  assign hz.stage_flush  = rst ? '0 : fl;
  assign hz.tgt_capture  = ~rst & cap;
  assign hz.tgt_held_sel = ~rst & (st == REDIR_WAIT);
  assign hz.predict_en   = ~rst & (en[1] | en[2]);
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  // saturating counts of frozen-PC cycles and flush cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!en[0] && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if ((|fl) && !(&flush_q)) flush_q <= flush_q + 1'b1;
    end
  end
  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random stimulus against a bubble-count reference model
module tb_pipeline_hazard_ctrl;
  localparam int N = 5;
  localparam int LUS = 2;
  localparam logic [N-1:0] ALL = {N{1'b1}};
  logic clk = 1'b0;
  logic rst;
  int passed = 0;
  int total = 0;
  bit pending;
  int left;
  int m_stall, m_flush;
  logic [N-1:0] e_en, e_fl;
  logic e_cap, e_held;
  bit n_pending;
  int n_left;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl_if #(.NUM_STAGES(N), .REG_ADDR_W(5), .CNT_W(32)) hz();
  pipeline_hazard_ctrl #(.NUM_STAGES(N), .LOAD_USE_STALLS(LUS), .REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .hz(hz)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    else passed++;
  endtask
  task automatic drive(input bit im, input bit dq, input bit dr, input bit bz, input int r1, input int r2,
                       input bit ld, input int rd, input bit rdir);
    hz.imem_resp = im; hz.dmem_req = dq; hz.dmem_resp = dr; hz.ex_busy = bz;
    hz.rs1_id = 5'(r1); hz.rs2_id = 5'(r2); hz.ex_is_load = ld; hz.rd_ex = 5'(rd); hz.redirect = rdir;
  endtask
  task automatic model_eval();
    bit bok, fok, hit;
    bok = (!hz.dmem_req || hz.dmem_resp) && !hz.ex_busy;
    fok = hz.imem_resp;
    hit = hz.ex_is_load && hz.rd_ex != 0 && (hz.rd_ex == hz.rs1_id || hz.rd_ex == hz.rs2_id);
    e_en = '0; e_fl = '0; e_cap = 1'b0; e_held = pending;
    n_pending = pending; n_left = left;
    if (bok) begin
      if (hz.redirect) begin
        e_en = ALL; e_fl = N'(6); n_left = 0;
        if (fok && !pending) n_pending = 0;
        else begin e_en[0] = 1'b0; e_cap = 1'b1; n_pending = 1; end
      end else if (pending) begin
        e_en = ALL; e_en[0] = fok; e_fl = N'(2); n_pending = !fok;
      end else if (left > 0 || hit) begin
        e_en = ALL - N'(3); e_fl = N'(4); n_left = (left > 0) ? left - 1 : LUS - 1;
      end else begin
        e_en = ALL; e_en[0] = fok; e_fl = fok ? '0 : N'(2);
      end
    end
  endtask
  task automatic check_all();
    chk("stage_en", 32'(hz.stage_en), 32'(e_en));
    chk("stage_flush", 32'(hz.stage_flush), 32'(e_fl));
    chk("tgt_capture", 32'(hz.tgt_capture), 32'(e_cap));
    chk("tgt_held_sel", 32'(hz.tgt_held_sel), 32'(e_held));
    chk("predict_en", 32'(hz.predict_en), 32'(e_en[1] | e_en[2]));
    chk("stall_cnt", hz.stall_cnt, 32'(m_stall));
    chk("flush_cnt", hz.flush_cnt, 32'(m_flush));
  endtask
  task automatic step();
    #1;
    model_eval();
    check_all();
    @(posedge clk);
`ifdef HAZARD_PERF_EN
    if (!e_en[0]) m_stall++;
    if (|e_fl) m_flush++;
`endif
    pending = n_pending;
    left = n_left;
    @(negedge clk);
  endtask
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    pending = 0; left = 0; m_stall = 0; m_flush = 0;
    e_en = '0; e_fl = '0; e_cap = 1'b0; e_held = 1'b0;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    pending = 0; left = 0; m_stall = 0; m_flush = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    e_en = '0; e_fl = '0; e_cap = 1'b0; e_held = 1'b0;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    drive(1, 0, 0, 0, 5, 7, 1, 5, 0); step(); step();
    drive(1, 0, 0, 0, 1, 2, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0); step(); step();
    drive(1, 0, 0, 0, 1, 2, 0, 0, 1); step();
    drive(1, 0, 0, 0, 1, 2, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 2, 0, 0, 1); step();
    drive(0, 0, 0, 0, 1, 2, 0, 0, 0); step(); step(); step();
    drive(1, 0, 0, 0, 1, 2, 0, 0, 0); step(); step();
    drive(1, 1, 0, 0, 3, 9, 1, 9, 0); for (int i = 0; i < 4; i++) step();
    drive(1, 1, 1, 0, 3, 9, 1, 9, 0); step();
    drive(1, 1, 0, 0, 3, 9, 0, 9, 0); step(); step();
    drive(1, 0, 0, 0, 3, 9, 0, 9, 0); step(); step();
    drive(0, 0, 0, 0, 1, 2, 0, 0, 1); step();
    drive(0, 0, 0, 0, 1, 2, 0, 0, 0); step();
    async_reset();
    drive(1, 0, 0, 0, 1, 2, 0, 0, 0); step();
    for (int i = 0; i < 2000; i++) begin
      drive($urandom % 4 != 0, $urandom % 3 == 0, $urandom % 2 == 1, $urandom % 6 == 0,
            $urandom % 4, $urandom % 4, $urandom % 2 == 1, $urandom % 4, $urandom % 8 == 0);
      if ($urandom % 200 == 0) async_reset();
      else step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
